// File: rtl/haar_cascade_ctrl.sv
// Haar cascade sequencer: raster-scans a WIN x WIN window over the image and runs
// each stage from a small writable table on a shared evaluator, rejecting a window
// at its first failing stage and reporting windows that pass every stage.
// Latency: start -> first stg_start 1 cycle; each evaluated stage is 1 ISSUE cycle
// plus WAIT cycles through stg_done; a skipped (num_feat=0) stage is 1 cycle;
// NEXT_WIN is 1 cycle per window.
// Backpressure: stalls in WAIT until stg_done; start and table writes are only
// honoured in IDLE.
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   start / busy / scan_done           scan control and status
//   cfg_we, cfg_idx, cfg_first_feat,
//   cfg_num_feat, cfg_threshold        stage-table write port (IDLE only)
//   stg_start, stg_first_feat,
//   stg_num_feat, stg_threshold        stage request to the evaluator
//   stg_done, stg_pass                 evaluator result
//   win_x, win_y, stage_idx            current window origin and stage
//   det_valid, det_x, det_y, det_count detection report and saturating count
module haar_cascade_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int WIN        = 24,
  parameter int STEP       = 2,
  parameter int COORD_W    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               scan_done,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_idx,
  input  logic [15:0]        cfg_first_feat,
  input  logic [15:0]        cfg_num_feat,
  input  logic [15:0]        cfg_threshold,
  output logic               stg_start,
  output logic [15:0]        stg_first_feat,
  output logic [15:0]        stg_num_feat,
  output logic [15:0]        stg_threshold,
  input  logic               stg_done,
  input  logic               stg_pass,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic [3:0]         stage_idx,
  output logic               det_valid,
  output logic [COORD_W-1:0] det_x,
  output logic [COORD_W-1:0] det_y,
  output logic [15:0]        det_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT_WIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Table is sized for the full 4-bit index so cfg_idx/stage_idx select it
  // directly; entries at or beyond NUM_STAGES are never written.
  logic [15:0] tbl_first [16];
  logic [15:0] tbl_num   [16];
  logic [15:0] tbl_thr   [16];

  logic        det_pending;
  logic        last_stage;
  logic        stage_resolved;
  logic        stage_passed;
  logic        x_fits;
  logic        y_fits;
  logic [15:0] cur_num;

  assign cur_num    = tbl_num[stage_idx];
  assign last_stage = (stage_idx == 4'(NUM_STAGES - 1));
  assign x_fits     = (32'(win_x) + 32'(STEP) + 32'(WIN)) <= 32'(IMG_W);
  assign y_fits     = (32'(win_y) + 32'(STEP) + 32'(WIN)) <= 32'(IMG_H);

  // A stage resolves either immediately (empty stage counts as a pass) or when
  // the evaluator answers in WAIT. stg_done in ISSUE is deliberately ignored.
  always_comb begin
    stage_resolved = 1'b0;
    stage_passed   = 1'b0;
    case (state)
      S_ISSUE: begin
        if (cur_num == 16'd0) begin
          stage_resolved = 1'b1;
          stage_passed   = 1'b1;
        end
      end
      S_WAIT: begin
        if (stg_done) begin
          stage_resolved = 1'b1;
          stage_passed   = stg_pass;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_ISSUE;
      S_ISSUE, S_WAIT: begin
        if (state == S_ISSUE && cur_num != 16'd0) state_nxt = S_WAIT;
        else if (stage_resolved) begin
          if (!stage_passed || last_stage) state_nxt = S_NEXT_WIN;
          else                             state_nxt = S_ISSUE;
        end
      end
      S_NEXT_WIN: state_nxt = (x_fits || y_fits) ? S_ISSUE : S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state != S_IDLE);
    scan_done = (state == S_DONE);
    stg_start = (state == S_ISSUE) && (cur_num != 16'd0);
    det_valid = (state == S_NEXT_WIN) && det_pending;
  end

  // Table and window registers only change in IDLE/ISSUE/WAIT/NEXT_WIN, so the
  // evaluator-facing values hold from ISSUE until the cycle after stg_done.
  assign stg_first_feat = tbl_first[stage_idx];
  assign stg_num_feat   = cur_num;
  assign stg_threshold  = tbl_thr[stage_idx];
  assign det_x          = win_x;
  assign det_y          = win_y;

  // Datapath: table, window position, stage index, detection bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        tbl_first[i] <= 16'd0;
        tbl_num[i]   <= 16'd0;
        tbl_thr[i]   <= 16'd0;
      end
      win_x       <= '0;
      win_y       <= '0;
      stage_idx   <= 4'd0;
      det_pending <= 1'b0;
      det_count   <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we && (32'(cfg_idx) < 32'(NUM_STAGES))) begin
            tbl_first[cfg_idx] <= cfg_first_feat;
            tbl_num[cfg_idx]   <= cfg_num_feat;
            tbl_thr[cfg_idx]   <= cfg_threshold;
          end
          if (start) begin
            win_x       <= '0;
            win_y       <= '0;
            stage_idx   <= 4'd0;
            det_pending <= 1'b0;
            det_count   <= 16'd0;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (stage_resolved && stage_passed) begin
            if (last_stage) det_pending <= 1'b1;
            else            stage_idx   <= stage_idx + 4'd1;
          end
        end
        S_NEXT_WIN: begin
          if (det_pending && det_count != 16'hFFFF) det_count <= det_count + 16'd1;
          det_pending <= 1'b0;
          stage_idx   <= 4'd0;
          if (x_fits) begin
            win_x <= win_x + COORD_W'(STEP);
          end else if (y_fits) begin
            win_x <= '0;
            win_y <= win_y + COORD_W'(STEP);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_haar_cascade_ctrl.sv
module tb_haar_cascade_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, cfg_we;
  logic [3:0]  cfg_idx;
  logic [15:0] cfg_first_feat, cfg_num_feat, cfg_threshold;
  logic        busy, scan_done, stg_start, det_valid;
  logic [15:0] stg_first_feat, stg_num_feat, stg_threshold, det_count;
  logic        stg_done, stg_pass;
  logic [9:0]  win_x, win_y, det_x, det_y;
  logic [3:0]  stage_idx;

  // Evaluator model and manual override both feed the result lines.
  logic ev_done = 1'b0, ev_pass = 1'b0, man_done = 1'b0, man_pass = 1'b0;
  assign stg_done = ev_done | man_done;
  assign stg_pass = ev_pass | man_pass;

  always #5 clk = ~clk;

  haar_cascade_ctrl #(
    .NUM_STAGES(2), .IMG_W(28), .IMG_H(26), .WIN(24), .STEP(2), .COORD_W(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .scan_done(scan_done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_first_feat(cfg_first_feat),
    .cfg_num_feat(cfg_num_feat), .cfg_threshold(cfg_threshold),
    .stg_start(stg_start), .stg_first_feat(stg_first_feat),
    .stg_num_feat(stg_num_feat), .stg_threshold(stg_threshold),
    .stg_done(stg_done), .stg_pass(stg_pass), .win_x(win_x), .win_y(win_y),
    .stage_idx(stage_idx), .det_valid(det_valid), .det_x(det_x), .det_y(det_y),
    .det_count(det_count)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  stg;
    logic [15:0] ff;
    logic [15:0] nf;
    logic [15:0] thr;
  } iss_t;

  iss_t        exp_iss[$];
  logic [19:0] exp_det[$];
  int          checks = 0;
  int          errors = 0;
  int          sd_cnt = 0;

  // Window origins in raster order for the 28x26 image, 24 window, stride 2.
  int wx[6] = '{0, 2, 4, 0, 2, 4};
  int wy[6] = '{0, 0, 0, 2, 2, 2};

  // Reference copy of the stage table (stages 0 and 1).
  logic [15:0] t_ff[2], t_nf[2], t_th[2];

  // Evaluator behaviour knobs.
  int   eval_mode  = 1;   // 0: silent, 1: answer every stg_start
  int   eval_delay = 1;
  logic spurious   = 1'b0;
  logic fail_en    = 1'b0;
  int   fail_x = 0, fail_y = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Evaluator model / issue scoreboard.
  initial begin : evaluator
    iss_t cur, e, now;
    logic stable, pass;
    forever begin
      @(posedge clk); #1;
      while (eval_mode != 0 && stg_start && !reset) begin
        cur = '{win_x, win_y, stage_idx, stg_first_feat, stg_num_feat, stg_threshold};
        checks++;
        if (exp_iss.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: got %h expected none", cur);
        end else begin
          e = exp_iss.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL issue: got %h expected %h", cur, e);
          end
        end
        pass = !(fail_en && cur.stg == 4'd0 && 32'(cur.x) == fail_x && 32'(cur.y) == fail_y);
        if (spurious) begin
          ev_done = 1'b1;
          ev_pass = 1'b0;
        end
        stable = 1'b1;
        for (int k = 1; k <= eval_delay; k++) begin
          @(posedge clk); #1;
          ev_done = 1'b0;
          ev_pass = 1'b0;
          now = '{win_x, win_y, stage_idx, stg_first_feat, stg_num_feat, stg_threshold};
          if (now != cur || stg_start) stable = 1'b0;
          if (k == eval_delay) begin
            ev_done = 1'b1;
            ev_pass = pass;
          end
        end
        @(posedge clk); #1;
        ev_done = 1'b0;
        ev_pass = 1'b0;
        check("hold_stable", int'(stable), 1);
      end
    end
  end

  // Detection monitor / scoreboard.
  always @(negedge clk) begin
    if (det_valid) begin
      if (exp_det.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL det_unexpected: got (%0d,%0d) expected none", det_x, det_y);
      end else begin
        check("det_xy", int'({det_x, det_y}), int'(exp_det.pop_front()));
      end
    end
    if (scan_done) sd_cnt++;
  end

  task automatic write_cfg(input int idx, input logic [15:0] ff, nf, th);
    cfg_we = 1'b1;
    cfg_idx = 4'(idx);
    cfg_first_feat = ff;
    cfg_num_feat = nf;
    cfg_threshold = th;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (idx < 2) begin
      t_ff[idx] = ff;
      t_nf[idx] = nf;
      t_th[idx] = th;
    end
  endtask

  // Push the expected stage requests and detections for one full scan.
  task automatic expect_scan(input int fail_w);
    iss_t e;
    logic failed;
    for (int w = 0; w < 6; w++) begin
      failed = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (!failed && t_nf[s] != 16'd0) begin
          e.x = 10'(wx[w]);
          e.y = 10'(wy[w]);
          e.stg = 4'(s);
          e.ff = t_ff[s];
          e.nf = t_nf[s];
          e.thr = t_th[s];
          exp_iss.push_back(e);
          if (w == fail_w && s == 0) failed = 1'b1;
        end
      end
      if (!failed) exp_det.push_back({10'(wx[w]), 10'(wy[w])});
    end
  endtask

  task automatic run_scan(input string name, input int exp_cycles, input int exp_dets,
                          input logic inject);
    int cyc;
    int sd0;
    sd0 = sd_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    if (inject) begin
      cfg_idx = 4'd0;
      cfg_first_feat = 16'h0099;
      cfg_num_feat = 16'd0;
      cfg_threshold = 16'd0;
    end
    while (!scan_done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (inject) begin
        start  = (cyc == 4 || cyc == 9);
        cfg_we = (cyc >= 4 && cyc <= 9);
      end
    end
    start = 1'b0;
    cfg_we = 1'b0;
    if (!scan_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no scan_done expected one within 2000 cycles", name);
    end
    check({name, "_cycles"}, cyc, exp_cycles);
    check({name, "_busy_in_done"}, int'(busy), 1);
    @(posedge clk); #1;
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_scan_done_after"}, int'(scan_done), 0);
    check({name, "_det_count"}, int'(det_count), exp_dets);
    check({name, "_pending_dets"}, exp_det.size(), 0);
    check({name, "_pending_issues"}, exp_iss.size(), 0);
    check({name, "_scan_done_pulses"}, sd_cnt - sd0, 1);
  endtask

  initial begin : main
    int sd0;
    reset = 1'b1;
    start = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = 4'd0;
    cfg_first_feat = 16'd0;
    cfg_num_feat = 16'd0;
    cfg_threshold = 16'd0;
    for (int i = 0; i < 2; i++) begin
      t_ff[i] = 16'd0;
      t_nf[i] = 16'd0;
      t_th[i] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_busy", int'(busy), 0);
    check("rst_scan_done", int'(scan_done), 0);
    check("rst_stg_start", int'(stg_start), 0);
    check("rst_det_valid", int'(det_valid), 0);
    check("rst_det_count", int'(det_count), 0);
    check("rst_win", int'({win_x, win_y}), 0);
    check("rst_stage_idx", int'(stage_idx), 0);
    check("rst_stg_fields", int'({stg_first_feat, stg_num_feat}) | int'(stg_threshold), 0);

    write_cfg(0, 16'h0010, 16'd3, 16'd5);
    write_cfg(1, 16'h0020, 16'd4, 16'hFFFD);
    write_cfg(2, 16'h0055, 16'd9, 16'd1);   // out of range, ignored

    // All stages pass one cycle after stg_start: 6 windows x 5 cycles.
    expect_scan(-1);
    run_scan("allpass", 30, 6, 1'b0);

    // Stage 0 fails only at (2,0).
    fail_en = 1'b1;
    fail_x = 2;
    fail_y = 0;
    expect_scan(1);
    run_scan("fail20", 28, 5, 1'b0);
    fail_en = 1'b0;

    // Stage 1 empty: never issued, every window still detected.
    write_cfg(1, 16'h0077, 16'd0, 16'h0007);
    expect_scan(-1);
    run_scan("skip1", 24, 6, 1'b0);
    write_cfg(1, 16'h0020, 16'd4, 16'hFFFD);

    // Slow evaluator with a spurious stg_done in every ISSUE cycle.
    eval_delay = 7;
    spurious = 1'b1;
    expect_scan(-1);
    run_scan("slow", 102, 6, 1'b0);
    eval_delay = 1;
    spurious = 1'b0;

    // Table writes and start pulses while busy are ignored.
    expect_scan(-1);
    run_scan("busyin", 30, 6, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("busyin_no_rescan", int'(busy), 0);

    // Reset three cycles into WAIT, then a late stg_done.
    eval_mode = 0;
    sd0 = sd_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rstw_stg_start", int'(stg_start), 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    man_done = 1'b1;
    man_pass = 1'b1;
    check("rstw_busy", int'(busy), 0);
    check("rstw_det_valid", int'(det_valid), 0);
    check("rstw_scan_done", int'(scan_done), 0);
    check("rstw_tbl_ff", int'(stg_first_feat), 0);
    check("rstw_tbl_nf", int'(stg_num_feat), 0);
    check("rstw_tbl_thr", int'(stg_threshold), 0);
    check("rstw_det_count", int'(det_count), 0);
    @(posedge clk); #1;
    man_done = 1'b0;
    man_pass = 1'b0;
    check("rstw_late_busy", int'(busy), 0);
    check("rstw_late_det_valid", int'(det_valid), 0);
    check("rstw_no_scan_done", sd_cnt - sd0, 0);
    for (int i = 0; i < 2; i++) begin
      t_ff[i] = 16'd0;
      t_nf[i] = 16'd0;
      t_th[i] = 16'd0;
    end
    eval_mode = 1;
    // Cleared table: every stage skipped, 3 cycles per window.
    expect_scan(-1);
    run_scan("rescan", 18, 6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
